// File: rtl/lycan_globals.sv
`default_nettype none
// ============================================================================
//  Module      : lycan_globals (package)
//  Description : Shared constants for the peripheral receive path.
//                num_peripherals    - number of peripheral receive channels
//                periph_addr_width  - width of a peripheral index (min 1)
//                rx_fifo_depth      - entries per peripheral FIFO (power of 2)
//                usb_packet_width   - payload width
//                rx_fifo_ptr_width  - FIFO binary pointer width
//                rx_fifo_cnt_width  - FIFO occupancy count width (holds depth)
//  Revision    : 1.0 - initial release
// ============================================================================
package lycan_globals;

    localparam int usb_packet_width  = 8;
    localparam int num_peripherals   = 4;
    localparam int periph_addr_width = (num_peripherals > 1) ? $clog2(num_peripherals) : 1;
    localparam int rx_fifo_depth     = 4;

    // Pointer width depends only on the FIFO depth, never on the peripheral
    // count. The count needs one extra bit so that "full" is representable.
    localparam int rx_fifo_ptr_width = (rx_fifo_depth > 1) ? $clog2(rx_fifo_depth) : 1;
    localparam int rx_fifo_cnt_width = rx_fifo_ptr_width + 1;

endpackage : lycan_globals
`default_nettype wire

// File: rtl/periph_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : periph_rx_fifo
//  Description : Private synchronous FIFO for one peripheral. Binary read and
//                write pointers wrap naturally at rx_fifo_depth (power of 2);
//                a registered count gives empty/full.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-high reset
//                wr_data  - payload to push
//                wr_en    - push request (ignored while full)
//                rd_en    - pop request (ignored while empty)
//                rd_data  - head entry, combinational from the read pointer
//                empty    - no entries held
//                full     - rx_fifo_depth entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_rx_fifo
    import lycan_globals::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [usb_packet_width-1:0] wr_data,
    input  logic                        wr_en,
    input  logic                        rd_en,
    output logic [usb_packet_width-1:0] rd_data,
    output logic                        empty,
    output logic                        full
);

    logic [usb_packet_width-1:0]  r_mem [rx_fifo_depth];
    logic [rx_fifo_ptr_width-1:0] r_wr_ptr;
    logic [rx_fifo_ptr_width-1:0] r_rd_ptr;
    logic [rx_fifo_cnt_width-1:0] r_count;

    logic w_push;
    logic w_pop;

    // full comes from the registered count only, so a pop in the same cycle
    // never makes room for a push.
    assign full    = (r_count == rx_fifo_cnt_width'(rx_fifo_depth));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : periph_rx_fifo
`default_nettype wire

// File: rtl/periph_rx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : periph_rx_arbiter
//  Description : Buffers per-peripheral receive payloads in private FIFOs and
//                merges them round-robin into one output register tagged
//                with the source peripheral index.
//  Ports       : clk          - rising-edge clock
//                rst          - synchronous active-high reset
//                rx_data      - packed per-peripheral payloads
//                rx_valid     - per-peripheral write strobes
//                rx_fifo_full - per-peripheral back-pressure
//                overflow     - sticky per-peripheral dropped-write flags
//                out_data     - granted payload
//                out_addr     - source peripheral index
//                out_valid    - output register holds a packet
//                out_ready    - consumer accepts when out_valid & out_ready
//                idle         - all FIFOs empty and no held packet
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_rx_arbiter
    import lycan_globals::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [num_peripherals*usb_packet_width-1:0] rx_data,
    input  logic [num_peripherals-1:0]                  rx_valid,
    output logic [num_peripherals-1:0]                  rx_fifo_full,
    output logic [num_peripherals-1:0]                  overflow,
    output logic [usb_packet_width-1:0]                 out_data,
    output logic [periph_addr_width-1:0]                out_addr,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        idle
);

    logic [usb_packet_width-1:0]  w_rd_data [num_peripherals];
    logic [num_peripherals-1:0]   w_empty;
    logic [num_peripherals-1:0]   w_full;
    logic [num_peripherals-1:0]   w_wr_en;
    logic [num_peripherals-1:0]   w_rd_en;
    logic [periph_addr_width-1:0] w_grant;
    logic                         w_found;
    logic                         w_load;

    logic [periph_addr_width-1:0] r_last_grant;
    logic [num_peripherals-1:0]   r_overflow;
    logic [usb_packet_width-1:0]  r_out_data;
    logic [periph_addr_width-1:0] r_out_addr;
    logic                         r_out_valid;

    generate
        for (genvar i = 0; i < num_peripherals; i++) begin : g_fifo
            assign w_wr_en[i] = rx_valid[i] && !w_full[i];
            // Pop only the granted FIFO, and only when the output register loads.
            assign w_rd_en[i] = w_load && (w_grant == periph_addr_width'(i));

            periph_rx_fifo u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_data (rx_data[i*usb_packet_width +: usb_packet_width]),
                .wr_en   (w_wr_en[i]),
                .rd_en   (w_rd_en[i]),
                .rd_data (w_rd_data[i]),
                .empty   (w_empty[i]),
                .full    (w_full[i])
            );
        end
    endgenerate

    // Round-robin search: start one past the last grant and take the first
    // non-empty FIFO, wrapping modulo num_peripherals.
    always_comb begin
        int w_idx;
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= num_peripherals; k++) begin
            w_idx = (int'(r_last_grant) + k) % num_peripherals;
            if (!w_found && !w_empty[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx[periph_addr_width-1:0];
            end
        end
    end

    // The output register accepts a new packet whenever it is empty or its
    // current packet is leaving this cycle; this gives one packet per cycle.
    assign w_load = (!r_out_valid || out_ready) && w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= periph_addr_width'(num_peripherals - 1);
            r_overflow   <= '0;
            r_out_data   <= '0;
            r_out_addr   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_overflow <= r_overflow | (rx_valid & w_full);
            if (w_load) begin
                r_out_data   <= w_rd_data[w_grant];
                r_out_addr   <= w_grant;
                r_out_valid  <= 1'b1;
                r_last_grant <= w_grant;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rx_fifo_full = w_full;
    assign overflow     = r_overflow;
    assign out_data     = r_out_data;
    assign out_addr     = r_out_addr;
    assign out_valid    = r_out_valid;
    assign idle         = (&w_empty) && !r_out_valid;

endmodule : periph_rx_arbiter
`default_nettype wire

// File: doc/periph_rx_arbiter.md
PERIPH_RX_ARBITER -- requirements
Module: periph_rx_arbiter

Interface
REQ-001 Parameters SHALL come from lycan_globals only; the block SHALL declare no local parameters.
REQ-002 clk  input  1  single clock for all logic, rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  num_peripherals x usb_packet_width  per-peripheral payload, no address field.
REQ-005 rx_valid  input  num_peripherals  per-peripheral write strobe, one payload per high cycle.
REQ-006 rx_fifo_full  output  num_peripherals  per-peripheral back-pressure; high when that FIFO holds rx_fifo_depth entries.
REQ-007 overflow  output  num_peripherals  sticky flag; set when a write is dropped.
REQ-008 out_data  output  usb_packet_width  granted payload.
REQ-009 out_addr  output  periph_addr_width  index of the source peripheral.
REQ-010 out_valid  output  1  out_data/out_addr hold a packet.
REQ-011 out_ready  input  1  consumer accepts the packet when out_valid and out_ready are both high.
REQ-012 idle  output  1  high when all FIFOs are empty and out_valid is low.

Function
REQ-013 Each peripheral SHALL own a private synchronous FIFO.
  - Depth rx_fifo_depth, a power of two, at least 2.
  - Binary read and write pointers of periph_addr-independent width, plus a count.
REQ-014 A write to FIFO i SHALL occur when rx_valid[i]=1 and rx_fifo_full[i]=0.
  - rx_fifo_full is derived from the registered count.
  - A simultaneous pop in the same cycle does not free space for that write.
REQ-015 If rx_valid[i]=1 while rx_fifo_full[i]=1:
  - the payload SHALL be dropped;
  - overflow[i] SHALL be set and stay set until reset.
REQ-016 Pointers SHALL wrap modulo rx_fifo_depth without a gap.
  - Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-017 The output register SHALL load when it is empty (out_valid=0) or being consumed (out_valid and out_ready), and at least one FIFO is non-empty.
  - On load, the granted FIFO SHALL be popped in the same cycle.
  - Throughput is one packet per cycle.
REQ-018 Grant SHALL be round-robin.
  - Search starts at last_grant+1 modulo num_peripherals.
  - The first non-empty FIFO wins; last_grant updates only on a load.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_addr SHALL remain stable and no pop SHALL occur.
REQ-020 When the output is consumed and all FIFOs are empty, out_valid SHALL deassert on the next cycle.
REQ-021 Latency: a payload written at edge N into an otherwise empty system with out_valid=0 SHALL appear with out_valid=1 after edge N+1.
REQ-022 out_addr SHALL equal the grant index, zero-extended to periph_addr_width.
REQ-023 idle SHALL be combinational from the registered FIFO counts and out_valid.
REQ-024 Packet order within one peripheral SHALL be preserved.
  - No packet is duplicated.
  - No packet is lost except per REQ-015.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL reset to:
  - all FIFO pointers and counts = 0;
  - overflow = 0;
  - out_valid = 0, out_data = 0, out_addr = 0;
  - last_grant = num_peripherals-1, so peripheral 0 has first priority.
REQ-026 After reset, rx_fifo_full = 0 and idle = 1.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered and held packets with no partial output.

Structure
REQ-028 lycan_globals SHALL hold these constants:
  - num_peripherals;
  - periph_addr_width = clog2(num_peripherals), minimum 1;
  - rx_fifo_depth;
  - usb_packet_width (existing).
REQ-029 The per-peripheral FIFO SHALL be a sub-module periph_rx_fifo, instantiated num_peripherals times via generate.
  - Ports: clk, rst, wr_data, wr_en, rd_en, rd_data (combinational from the read pointer), empty, full.
REQ-030 Round-robin grant, the output register and overflow flags SHALL live in periph_rx_arbiter.

Verification (num_peripherals=4, rx_fifo_depth=4, usb_packet_width=8)
REQ-031 Single packet: rx_valid[2] with 0xA5 for one cycle, out_ready=1 -> exactly one packet (out_data=0xA5, out_addr=2) two edges later; idle returns to 1.
REQ-032 Fairness: all four peripherals write 0x10+i each cycle for 4 cycles, out_ready=1 -> out_addr sequence 0,1,2,3,0,1,2,3,... and per-address data in order.
REQ-033 Full/overflow: out_ready=0, peripheral 1 writes 0x01..0x06 on consecutive cycles.
  - rx_fifo_full[1]=1 after the 0x05 write (4 in FIFO, 1 held at output) ... adjust: 0x01 held, 0x02..0x05 buffered.
  - 0x06 dropped; overflow[1]=1.
  - Releasing out_ready yields 0x01..0x05 only.
REQ-034 Stall: out_ready=0 for 10 cycles with a held packet -> out_data/out_addr unchanged, FIFO counts unchanged.
REQ-035 Wrap: 12 packets through peripheral 3 with alternating out_ready -> all 12 delivered in order, pointers wrap three times.
REQ-036 Reset mid-operation: rst for one cycle with FIFOs partly full and out_valid=1 -> next cycle out_valid=0, idle=1, overflow=0; the next grant goes to peripheral 0 first.
